dispatch_ctrl: RTL and testbench

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl_pkg.sv | 26 ++
 rtl/rob_tag_alloc.sv | 46 ++++
 rtl/dispatch_ctrl.sv | 77 +++++++
 tb/tb_dispatch_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared CPU constants: ROB sizing, dispatch unit encoding and decoder op codes.
package dispatch_ctrl_pkg;

  localparam int ROB_WIDTH = 4;

  localparam logic UNIT_RS  = 1'b0;
  localparam logic UNIT_LSB = 1'b1;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_BRANCH = 2'd1,
    OP_LOAD   = 2'd2,
    OP_STORE  = 2'd3
  } dec_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } disp_state_e;

  // Memory ops go to the load/store buffer, everything else to the reservation station.
  function automatic logic op_unit(input dec_op_e op);
    return (op == OP_LOAD || op == OP_STORE) ? UNIT_LSB : UNIT_RS;
  endfunction

endpackage

// File: rtl/rob_tag_alloc.sv
// ROB tag allocator: hands out sequential tags and tracks live ROB occupancy.
module rob_tag_alloc #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rdy,
  input  logic                 i_clear,
  input  logic                 i_fire,
  input  logic                 i_commit,
  output logic [ROB_WIDTH-1:0] o_next_tag,
  output logic [ROB_WIDTH:0]   o_rob_count,
  output logic                 o_has_space
);

  logic [ROB_WIDTH-1:0] r_next_tag;
  logic [ROB_WIDTH:0]   r_count;
  logic                 w_commit_eff;

  // A retire request against an empty ROB is spurious and must not underflow.
  assign w_commit_eff = i_commit & (r_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_next_tag <= '0;
      r_count    <= '0;
    end else if (i_clear) begin
      r_next_tag <= '0;
      r_count    <= '0;
    end else if (i_rdy) begin
      if (i_fire)
        r_next_tag <= r_next_tag + 1'b1;
      case ({i_fire, w_commit_eff})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_next_tag  = r_next_tag;
  assign o_rob_count = r_count;
  // Full exactly when the MSB of the count is set (count == 2^ROB_WIDTH).
  assign o_has_space = ~r_count[ROB_WIDTH];

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: holds one decoded instruction and issues it to the RS or LSB with a ROB tag.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH = dispatch_ctrl_pkg::ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_valid,
  input  logic                 dec_unit,
  output logic                 dec_ready,
  input  logic                 rs_space,
  input  logic                 lsb_space,
  input  logic                 commit,
  output logic                 issue_rs,
  output logic                 issue_lsb,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic [ROB_WIDTH-1:0] next_tag,
  output logic                 rob_has_space,
  output logic [ROB_WIDTH:0]   rob_count
);

  disp_state_e r_state;
  logic        r_unit;
  logic        w_unit_space;
  logic        w_fire;

  assign w_unit_space = (r_unit == UNIT_LSB) ? lsb_space : rs_space;
  assign w_fire       = (r_state == ST_HELD) & rdy_in & ~clear & rob_has_space & w_unit_space;
  // Accept when empty, or when the held entry leaves this same cycle.
  assign dec_ready    = rdy_in & ~clear & ((r_state == ST_EMPTY) | w_fire);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_EMPTY;
      r_unit    <= UNIT_RS;
      issue_rs  <= 1'b0;
      issue_lsb <= 1'b0;
      issue_tag <= '0;
    end else if (clear) begin
      r_state   <= ST_EMPTY;
      issue_rs  <= 1'b0;
      issue_lsb <= 1'b0;
    end else if (rdy_in) begin
      issue_rs  <= w_fire & (r_unit == UNIT_RS);
      issue_lsb <= w_fire & (r_unit == UNIT_LSB);
      if (w_fire)
        issue_tag <= next_tag;
      if (dec_valid & dec_ready) begin
        r_state <= ST_HELD;
        r_unit  <= dec_unit;
      end else if (w_fire) begin
        r_state <= ST_EMPTY;
      end
    end else begin
      issue_rs  <= 1'b0;
      issue_lsb <= 1'b0;
    end
  end

  rob_tag_alloc #(
    .ROB_WIDTH (ROB_WIDTH)
  ) u_rob_tag_alloc (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_rdy       (rdy_in),
    .i_clear     (clear),
    .i_fire      (w_fire),
    .i_commit    (commit),
    .o_next_tag  (next_tag),
    .o_rob_count (rob_count),
    .o_has_space (rob_has_space)
  );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_dispatch_ctrl;

  localparam int RW    = 4;
  localparam int DEPTH = 1 << RW;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, dec_valid, dec_unit, rs_space, lsb_space, commit;
  logic          dec_ready, issue_rs, issue_lsb, rob_has_space;
  logic [RW-1:0] issue_tag, next_tag;
  logic [RW:0]   rob_count;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: a one-slot holding buffer plus integer occupancy and tag counters.
  bit m_held, m_unit, m_rs, m_lsb;
  int m_count, m_tag, m_itag;

  dispatch_ctrl #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_valid(dec_valid), .dec_unit(dec_unit), .dec_ready(dec_ready),
    .rs_space(rs_space), .lsb_space(lsb_space), .commit(commit),
    .issue_rs(issue_rs), .issue_lsb(issue_lsb), .issue_tag(issue_tag),
    .next_tag(next_tag), .rob_has_space(rob_has_space), .rob_count(rob_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_unit = 0; m_rs = 0; m_lsb = 0;
    m_count = 0; m_tag = 0; m_itag = 0;
  endtask

  task automatic check_regs();
    chk("issue_rs", issue_rs, m_rs);
    chk("issue_lsb", issue_lsb, m_lsb);
    if (m_rs || m_lsb) chk("issue_tag", issue_tag, m_itag);
    chk("next_tag", next_tag, m_tag);
    chk("rob_count", rob_count, m_count);
    chk("rob_has_space", rob_has_space, m_count < DEPTH);
  endtask

  // One clock: apply inputs, check the combinational handshake, clock, update model, check registers.
  task automatic step(input bit v, input bit u, input bit rs, input bit ls,
                      input bit cm, input bit rd, input bit cl);
    bit f, acc;
    dec_valid = v; dec_unit = u; rs_space = rs; lsb_space = ls;
    commit = cm; rdy_in = rd; clear = cl;
    #1;
    f   = m_held && rd && !cl && (m_count < DEPTH) && (m_unit ? ls : rs);
    acc = rd && !cl && (!m_held || f);
    chk("dec_ready", dec_ready, acc);
    @(posedge clk_in); #1;
    if (cl) begin
      m_held = 0; m_count = 0; m_tag = 0; m_rs = 0; m_lsb = 0;
    end else if (!rd) begin
      m_rs = 0; m_lsb = 0;
    end else begin
      m_rs  = f && !m_unit;
      m_lsb = f && m_unit;
      if (f) m_itag = m_tag;
      m_count = m_count + (f ? 1 : 0) - ((cm && m_count > 0) ? 1 : 0);
      if (f) m_tag = (m_tag + 1) % DEPTH;
      if (v && acc) begin
        m_held = 1; m_unit = u;
      end else if (f) begin
        m_held = 0;
      end
    end
    check_regs();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; dec_valid = 1'b0; dec_unit = 1'b0;
    rs_space = 1'b0; lsb_space = 1'b0; commit = 1'b0;
    model_reset();
    @(posedge clk_in); #1;
    chk("rst_issue_tag", issue_tag, 0);
    check_regs();
    rst_in = 1'b0;

    // Single RS dispatch straight out of reset.
    step(1, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    chk("d033_issue_rs", issue_rs, 1);
    chk("d033_tag", issue_tag, 0);
    chk("d033_next_tag", next_tag, 1);
    step(0, 0, 1, 0, 0, 1, 1);

    // Fill the ROB with back-to-back LSB instructions; the 17th stays held.
    for (int i = 0; i <= DEPTH; i++) begin
      step(1, 1, 0, 1, 0, 1, 0);
      if (i >= 1) begin
        chk("d034_issue_lsb", issue_lsb, 1);
        chk("d034_tag", issue_tag, i - 1);
      end
    end
    step(1, 1, 0, 1, 0, 1, 0);
    chk("d034_full_space", rob_has_space, 0);
    chk("d034_full_strobe", issue_lsb, 0);

    // One commit frees one slot: exactly one dispatch with the wrapped tag.
    step(0, 1, 0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("d035_issue_lsb", issue_lsb, 1);
    chk("d035_wrap_tag", issue_tag, 0);
    chk("d035_count", rob_count, DEPTH);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("d035_single", issue_lsb, 0);

    // RS back-pressure for five cycles.
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    chk("d036_issue_rs", issue_rs, 1);
    chk("d036_count", rob_count, 1);

    // Flush while holding with seven live entries.
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 1, 0);
    chk("d037_pre_count", rob_count, 7);
    step(0, 0, 1, 0, 0, 1, 1);
    chk("d037_count", rob_count, 0);
    chk("d037_tag", next_tag, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    chk("d037_no_strobe", issue_rs, 0);

    // Global stall while holding with space available.
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0, 0);
      chk("d038_stall_count", rob_count, 0);
    end
    step(0, 0, 1, 1, 0, 1, 0);
    chk("d038_resume", issue_rs, 1);

    // Asynchronous reset: clears a live strobe immediately and drops a held entry.
    step(1, 1, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    chk("rst_pre_strobe", issue_lsb, 1);
    rst_in = 1'b1;
    #1;
    chk("rst_async_strobe", issue_lsb, 0);
    chk("rst_async_count", rob_count, 0);
    model_reset();
    #1 rst_in = 1'b0;
    step(0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
